// File: rtl/pc_ctrl_if.sv
// pc_ctrl_if: branch-resolution handshake between the execute stage and the PC controller.
//   i_br_valid  - execute stage presents a resolved control-flow instruction
//   i_br_jump   - instruction is unconditional (JAL/JALR)
//   i_br_taken  - compare-unit result, ignored for jumps
//   i_br_target - redirect target address
//   o_br_ready  - PC controller accepts the presented branch this cycle
//   Signal prefixes are from the PC controller's point of view.
//   modport master: execute stage (drives payload, samples ready)
//   modport slave : PC controller (samples payload, drives ready)
interface pc_ctrl_if;
    logic        i_br_valid;
    logic        i_br_jump;
    logic        i_br_taken;
    logic [31:0] i_br_target;
    logic        o_br_ready;

    modport master (
        output i_br_valid,
        output i_br_jump,
        output i_br_taken,
        output i_br_target,
        input  o_br_ready
    );

    modport slave (
        input  i_br_valid,
        input  i_br_jump,
        input  i_br_taken,
        input  i_br_target,
        output o_br_ready
    );
endinterface

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch PC sequencer with branch redirect, one-cycle flush, misalignment halt and statistics.
//   i_clk       - single clock, all state on the rising edge
//   i_rst_n     - synchronous active-low reset
//   i_stall     - fetch side cannot take a new PC this cycle
//   br          - branch handshake (pc_ctrl_if.slave)
//   o_pc        - current fetch PC
//   o_pc_valid  - o_pc is a fetch request (RUN only)
//   o_flush     - kill IF/ID instructions (FLUSH only)
//   o_misalign  - sticky misaligned-target fault
//   o_br_cnt    - saturating count of accepted branches
//   o_taken_cnt - saturating count of accepted redirects
module pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_stall,
    pc_ctrl_if.slave         br,
    output logic [31:0]      o_pc,
    output logic             o_pc_valid,
    output logic             o_flush,
    output logic             o_misalign,
    output logic [CNT_W-1:0] o_br_cnt,
    output logic [CNT_W-1:0] o_taken_cnt
);
    typedef enum logic [1:0] {RUN, FLUSH, HALT} state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic             accept;
    logic             redirect;
    logic             tgt_misaligned;

    // Ready depends only on state, so the payload is never looked at outside RUN.
    assign br.o_br_ready   = (state_q == RUN);
    assign accept          = br.i_br_valid & br.o_br_ready;
    assign redirect        = accept & (br.i_br_jump | br.i_br_taken);
    assign tgt_misaligned  = |br.i_br_target[1:0];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = misalign_q;
        case (state_q)
            RUN: begin
                // A redirect wins over a stall: the old sequential stream is dead anyway.
                if (redirect) begin
                    if (tgt_misaligned) begin
                        state_d    = HALT;
                        misalign_d = 1'b1;
                    end else begin
                        state_d = FLUSH;
                        pc_d    = br.i_br_target;
                    end
                end else if (!i_stall) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            FLUSH:   state_d = RUN;
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
    end

    // Counters stop at all-ones; misaligned redirects still count.
    assign br_cnt_d    = (accept && !(&br_cnt_q)) ? br_cnt_q + CNT_W'(1) : br_cnt_q;
    assign taken_cnt_d = (redirect && !(&taken_cnt_q)) ? taken_cnt_q + CNT_W'(1) : taken_cnt_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            misalign_q  <= 1'b0;
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            misalign_q  <= misalign_d;
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign o_pc        = pc_q;
    assign o_pc_valid  = (state_q == RUN);
    assign o_flush     = (state_q == FLUSH);
    assign o_misalign  = misalign_q;
    assign o_br_cnt    = br_cnt_q;
    assign o_taken_cnt = taken_cnt_q;
endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed bench for pc_ctrl with a reference model feeding an expected-output queue.
module tb_pc_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, stall, valid, jump, taken;
    logic [31:0] target;

    pc_ctrl_if bus();
    pc_ctrl_if bus2();
    assign bus.i_br_valid   = valid;
    assign bus.i_br_jump    = jump;
    assign bus.i_br_taken   = taken;
    assign bus.i_br_target  = target;
    assign bus2.i_br_valid  = valid;
    assign bus2.i_br_jump   = jump;
    assign bus2.i_br_taken  = taken;
    assign bus2.i_br_target = target;

    logic [31:0] pc, pc2;
    logic        pv, fl, mis, pv2, fl2, mis2;
    logic [15:0] bc, tc;
    logic [1:0]  bc2, tc2;

    pc_ctrl #(.RESET_PC(32'h0), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .br(bus.slave),
        .o_pc(pc), .o_pc_valid(pv), .o_flush(fl), .o_misalign(mis),
        .o_br_cnt(bc), .o_taken_cnt(tc)
    );

    pc_ctrl #(.RESET_PC(32'h0), .CNT_W(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .br(bus2.slave),
        .o_pc(pc2), .o_pc_valid(pv2), .o_flush(fl2), .o_misalign(mis2),
        .o_br_cnt(bc2), .o_taken_cnt(tc2)
    );

    typedef struct {
        logic [31:0] pc;
        logic        v, f, m, r;
        logic [15:0] bc, tc;
        logic [1:0]  bc2, tc2;
    } exp_t;

    exp_t q[$];
    int n_chk = 0, n_pass = 0, n_fail = 0;

    // reference model state: 0=RUN 1=FLUSH 2=HALT
    int          m_st = 0;
    logic [31:0] m_pc = 0;
    logic        m_mis = 0;
    logic [15:0] m_bc = 0, m_tc = 0;
    logic [1:0]  m_bc2 = 0, m_tc2 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic v, input logic j, input logic t, input logic [31:0] tg);
        stall = s; valid = v; jump = j; taken = t; target = tg;
    endtask

    task automatic cyc();
        exp_t e;
        if (!rst_n) begin
            m_st = 0; m_pc = 32'h0; m_mis = 0; m_bc = 0; m_tc = 0; m_bc2 = 0; m_tc2 = 0;
        end else if (m_st == 0) begin
            if (valid) begin
                m_bc  = (m_bc == 16'hFFFF) ? m_bc : m_bc + 16'd1;
                m_bc2 = (m_bc2 == 2'd3) ? m_bc2 : m_bc2 + 2'd1;
                if (jump || taken) begin
                    m_tc  = (m_tc == 16'hFFFF) ? m_tc : m_tc + 16'd1;
                    m_tc2 = (m_tc2 == 2'd3) ? m_tc2 : m_tc2 + 2'd1;
                    if (target[1:0] != 2'b00) begin
                        m_mis = 1; m_st = 2;
                    end else begin
                        m_pc = target; m_st = 1;
                    end
                end else if (!stall) m_pc = m_pc + 32'd4;
            end else if (!stall) m_pc = m_pc + 32'd4;
        end else if (m_st == 1) m_st = 0;
        e.pc = m_pc; e.v = (m_st == 0); e.f = (m_st == 1); e.m = m_mis; e.r = (m_st == 0);
        e.bc = m_bc; e.tc = m_tc; e.bc2 = m_bc2; e.tc2 = m_tc2;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("pc", pc, e.pc);
        chk("pc_valid", 32'(pv), 32'(e.v));
        chk("flush", 32'(fl), 32'(e.f));
        chk("misalign", 32'(mis), 32'(e.m));
        chk("br_ready", 32'(bus.o_br_ready), 32'(e.r));
        chk("br_cnt", 32'(bc), 32'(e.bc));
        chk("taken_cnt", 32'(tc), 32'(e.tc));
        chk("pc_w2", pc2, e.pc);
        chk("flush_w2", 32'(fl2), 32'(e.f));
        chk("valid_w2", 32'(pv2), 32'(e.v));
        chk("misalign_w2", 32'(mis2), 32'(e.m));
        chk("br_ready_w2", 32'(bus2.o_br_ready), 32'(e.r));
        chk("br_cnt_w2", 32'(bc2), 32'(e.bc2));
        chk("taken_cnt_w2", 32'(tc2), 32'(e.tc2));
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 32'h0);
        cyc(); cyc();
        chk("rst_pc", pc, 32'h0);
        chk("rst_ready", 32'(bus.o_br_ready), 32'h1);
        rst_n = 1'b1;
        // sequential fetch
        cyc(); cyc(); cyc();
        chk("seq_pc_c", pc, 32'hC);
        cyc();
        chk("seq_pc_10", pc, 32'h10);
        // taken branch to 0x100
        drive(0, 1, 0, 1, 32'h100);
        cyc();
        chk("br_flush", 32'(fl), 32'h1);
        chk("br_flush_pc", pc, 32'h100);
        chk("br_flush_nvalid", 32'(pv), 32'h0);
        drive(0, 0, 0, 0, 32'h0);
        cyc();
        chk("br_run_pc", pc, 32'h100);
        chk("br_run_valid", 32'(pv), 32'h1);
        chk("br_cnt1", 32'(bc), 32'h1);
        chk("taken_cnt1", 32'(tc), 32'h1);
        // jump to 0x20, then not-taken branch under stall
        drive(0, 1, 1, 0, 32'h20);
        cyc();
        drive(0, 0, 0, 0, 32'h0);
        cyc();
        drive(1, 1, 0, 0, 32'h40);
        cyc();
        chk("nt_pc_hold", pc, 32'h20);
        chk("nt_noflush", 32'(fl), 32'h0);
        chk("nt_br_cnt", 32'(bc), 32'h3);
        chk("nt_taken_cnt", 32'(tc), 32'h2);
        // redirect beats stall; next branch waits through FLUSH
        drive(1, 1, 0, 1, 32'h200);
        cyc();
        chk("stall_redir_pc", pc, 32'h200);
        chk("stall_redir_flush", 32'(fl), 32'h1);
        drive(1, 1, 1, 0, 32'h300);
        cyc();
        chk("flush_no_accept", 32'(bc), 32'h4);
        cyc();
        chk("held_accept_pc", pc, 32'h300);
        drive(0, 0, 0, 0, 32'h0);
        cyc();
        drive(1, 0, 0, 0, 32'h0);
        cyc();
        // not-taken branch with misaligned target is harmless
        drive(0, 1, 0, 0, 32'h103);
        cyc();
        chk("nt_mis_ok", 32'(mis), 32'h0);
        // wrap at 2^32
        drive(0, 1, 1, 0, 32'hFFFF_FFFC);
        cyc();
        drive(0, 0, 0, 0, 32'h0);
        cyc(); cyc();
        chk("wrap_pc", pc, 32'h0);
        // misaligned jump -> HALT
        drive(0, 1, 1, 0, 32'h102);
        cyc();
        chk("halt_mis", 32'(mis), 32'h1);
        chk("halt_pc", pc, 32'h0);
        for (int i = 0; i < 12; i++) begin
            drive(i[0], 1, 0, 1, 32'h400);
            cyc();
        end
        chk("halt_still_mis", 32'(mis), 32'h1);
        chk("halt_nvalid", 32'(pv), 32'h0);
        chk("halt_nready", 32'(bus.o_br_ready), 32'h0);
        chk("halt_br_cnt", 32'(bc), 32'h8);
        // reset out of HALT with a branch still presented
        rst_n = 1'b0;
        cyc();
        chk("halt_rst_mis", 32'(mis), 32'h0);
        chk("halt_rst_cnt", 32'(bc), 32'h0);
        chk("halt_rst_valid", 32'(pv), 32'h1);
        rst_n = 1'b1;
        // reset in the middle of FLUSH
        drive(0, 1, 0, 1, 32'h80);
        cyc();
        rst_n = 1'b0;
        cyc();
        chk("flush_rst_flush", 32'(fl), 32'h0);
        chk("flush_rst_pc", pc, 32'h0);
        rst_n = 1'b1;
        // five redirects saturate the 2-bit counters
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 1, 0, 32'h1000 + 32'(i) * 32'h10);
            cyc();
            drive(0, 0, 0, 0, 32'h0);
            cyc();
        end
        cyc(); cyc();
        chk("sat_br_cnt_w2", 32'(bc2), 32'h3);
        chk("sat_taken_cnt_w2", 32'(tc2), 32'h3);
        chk("sat_br_cnt", 32'(bc), 32'h5);
        chk("sat_taken_cnt", 32'(tc), 32'h5);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the fetch PC loaded at reset.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of both statistics counters.
REQ-003 i_clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 i_rst_n  input  1  SHALL be a synchronous, active-low reset.
REQ-005 i_stall  input  1  SHALL mean the fetch side cannot accept a new PC this cycle.
REQ-006 i_br_valid  input  1  SHALL mean the execute stage presents a resolved control-flow instruction.
REQ-007 i_br_jump  input  1  SHALL mean the instruction is unconditional (JAL/JALR).
REQ-008 i_br_taken  input  1  SHALL be the compare-unit taken result, ignored when i_br_jump=1.
REQ-009 i_br_target  input  32  SHALL be the redirect target address.
REQ-010 o_br_ready  output  1  SHALL mean a presented branch is accepted this cycle.
REQ-011 o_pc  output  32  SHALL be the current fetch PC.
REQ-012 o_pc_valid  output  1  SHALL mean o_pc is a fetch request.
REQ-013 o_flush  output  1  SHALL mean IF/ID instructions are to be killed.
REQ-014 o_misalign  output  1  SHALL be a sticky misaligned-target fault flag.
REQ-015 o_br_cnt  output  CNT_W  SHALL count accepted branches.
REQ-016 o_taken_cnt  output  CNT_W  SHALL count accepted redirects.

Function
REQ-017 The FSM SHALL have exactly three states: RUN, FLUSH, HALT.
REQ-018 Accept SHALL mean i_br_valid=1 and o_br_ready=1 at a rising edge; redirect SHALL mean accept with (i_br_jump | i_br_taken).
REQ-019 o_br_ready SHALL be combinationally 1 in RUN and 0 in FLUSH and HALT, independent of i_stall.
REQ-020 i_br_valid and its payload SHALL be held by the source until accept; the block SHALL not depend on payload while o_br_ready=0.
REQ-021 RUN, no redirect, i_stall=0: o_pc SHALL become o_pc+4 at the next edge, wrapping modulo 2^32.
REQ-022 RUN, no redirect, i_stall=1: o_pc SHALL hold.
REQ-023 RUN, redirect, i_br_target[1:0]=0: o_pc SHALL become i_br_target and state SHALL become FLUSH, regardless of i_stall (redirect beats stall).
REQ-024 RUN, redirect, i_br_target[1:0]!=0: o_pc SHALL hold, o_misalign SHALL become 1, state SHALL become HALT.
REQ-025 FLUSH SHALL last exactly one cycle, then return to RUN; o_pc SHALL hold during FLUSH.
REQ-026 o_flush SHALL be 1 exactly in FLUSH cycles and 0 otherwise.
REQ-027 o_pc_valid SHALL be 1 in RUN and 0 in FLUSH and HALT.
REQ-028 HALT SHALL be left only by reset; o_misalign SHALL stay 1 throughout HALT.
REQ-029 o_br_cnt SHALL increment by 1 on every accept, including misaligned ones; o_taken_cnt SHALL increment by 1 on every redirect, including misaligned ones.
REQ-030 Both counters SHALL saturate at all-ones and never wrap.
REQ-031 Latency SHALL be: redirect accepted at edge N; target fetch first valid at edge N+2.

Reset
REQ-032 With i_rst_n=0 at an edge, reset SHALL override all other inputs, including mid-FLUSH and HALT.
REQ-033 Reset values SHALL be: o_pc=RESET_PC, state RUN, o_pc_valid=1, o_br_ready=1, o_flush=0, o_misalign=0, o_br_cnt=0, o_taken_cnt=0.

Verification
REQ-034 Reset, then i_stall=0 and no branch for 3 edges -> o_pc 0x0, 0x4, 0x8, 0xC, with o_pc_valid=1 throughout.
REQ-035 In RUN at o_pc=0x10: i_br_valid=1, i_br_taken=1, target 0x100 -> next cycle o_pc=0x100, o_flush=1, o_pc_valid=0, o_br_ready=0; the cycle after: RUN, o_pc=0x100 valid; o_br_cnt=1, o_taken_cnt=1.
REQ-036 i_br_valid=1, i_br_jump=0, i_br_taken=0 at o_pc=0x20 with i_stall=1 -> accepted, o_pc holds 0x20, no flush, o_br_cnt+1, o_taken_cnt unchanged.
REQ-037 Redirect to 0x200 with i_stall=1 in the same cycle -> o_pc=0x200, FLUSH entered (redirect beats stall).
REQ-038 Jump to 0x102 -> o_misalign=1, HALT, o_pc_valid=0, o_br_ready=0 for 10+ cycles; then i_rst_n=0 for one edge -> all outputs at reset values.
REQ-039 With CNT_W=2, issue 5 redirects -> o_br_cnt=3 and o_taken_cnt=3, held there.
